// File: rtl/disp_pkg.sv
// disp_pkg: types and constants shared by the 7-segment display path.
//
// Contents:
//   nibble_t  - one hex digit (4 bits)
//   seg_t     - active-low segment vector, bit order g,f,e,d,c,b,a
//   N_DIGITS  - number of multiplexed digit positions
//   SEG_HEX   - active-low gfedcba pattern for hex values 0..F; entry i is
//               the pattern that displays value i. The display controller
//               drives from the same table, so capture and drive cannot drift.
package disp_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam int N_DIGITS = 4;

    // Written MSB-first, so the last element is entry 0.
    localparam seg_t [15:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // All segments dark on all positions: the idle {an,seg} sample.
    localparam logic [10:0] SMP_IDLE = 11'h7FF;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational reverse lookup of an active-low 7-segment
// pattern into the hex value it displays.
//
// Ports:
//   seg    in  7  active-low segments, g,f,e,d,c,b,a
//   hit    out 1  pattern matches an entry of SEG_HEX
//   nibble out 4  matching value; 0 when there is no match
module seg_decode
    import disp_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    // Table entries are all distinct, so at most one compare can match.
    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_HEX[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/disp_capture.sv
// disp_capture: passive observer of a multiplexed 4-digit 7-segment display.
// Samples {an,seg} every clock, accepts a pattern once it has been seen on
// STABLE consecutive samples, decodes the lit digit, and publishes a 16-bit
// frame after all four positions have been accepted.
//
// Parameters:
//   STABLE  consecutive identical samples needed to accept (>= 1)
//
// Ports:
//   clk     in  1   system clock, rising edge
//   reset   in  1   asynchronous active-high reset
//   an      in  4   anode enables, active-low; an[i]=0 lights digit i
//   seg     in  7   segments, active-low, g,f,e,d,c,b,a
//   digits  out 16  last complete frame, digit i in [4i+3:4i]
//   valid   out 1   one-cycle pulse when digits is updated
//   err     out 1   sticky error flag
//
// Build option:
//   DISP_CAPTURE_ERR_EN  when defined, err sets on an accepted-length run
//                        with more than one anode low, or with a segment
//                        pattern not in the table. Otherwise err is 0 and
//                        such runs are ignored / decoded as 0.
module disp_capture
    import disp_pkg::*;
#(
    parameter int STABLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        valid,
    output logic        err
);

    localparam int CW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [10:0]                smp_q,    smp_d;
    logic [CW-1:0]              cnt_q,    cnt_d;
    nibble_t [N_DIGITS-1:0]     buf_q,    buf_d;
    logic [N_DIGITS-1:0]        seen_q,   seen_d;
    logic [15:0]                digits_q, digits_d;
    logic                       valid_q,  valid_d;

    // ------------------------------------------------------------------
    // Input analysis
    // ------------------------------------------------------------------
    logic [10:0]         sample;
    logic                same;
    logic                reach;
    logic [2:0]          n_low;
    logic                one_low;
    logic [N_DIGITS-1:0] slot_sel;
    logic [1:0]          slot_idx;
    logic                dec_hit;
    logic [3:0]          dec_nibble;
    nibble_t             nib;
    logic                accept;

    assign sample = {an, seg};
    assign same   = (sample == smp_q);

    // Run counter: reload to 1 on any change, otherwise count up and hold
    // at STABLE.
    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = CW'(1);
        end else if (cnt_q != STABLE_C) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The run reaches STABLE on exactly one edge: once saturated with the
    // same input, cnt_d equals STABLE again but that is not a new arrival.
    assign reach = (cnt_d == STABLE_C) && !(same && (cnt_q == STABLE_C));

    // Count low anodes and locate the selected position.
    always_comb begin
        n_low    = 3'd0;
        slot_idx = 2'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an[i]) begin
                n_low    = n_low + 3'd1;
                slot_idx = 2'(i);
            end
        end
    end

    assign one_low = (n_low == 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_sel
            assign slot_sel[gi] = one_low && !an[gi];
        end
    endgenerate

    seg_decode u_seg_decode (
        .seg    (seg),
        .hit    (dec_hit),
        .nibble (dec_nibble)
    );

    // Unknown patterns land in the buffer as 0.
    assign nib    = dec_hit ? dec_nibble : 4'h0;
    assign accept = reach && one_low;

    // ------------------------------------------------------------------
    // Frame assembly
    // ------------------------------------------------------------------
    logic [N_DIGITS-1:0] seen_nx;

    always_comb begin
        smp_d    = sample;
        buf_d    = buf_q;
        seen_d   = seen_q;
        digits_d = digits_q;
        valid_d  = 1'b0;
        seen_nx  = seen_q | slot_sel;
        if (accept) begin
            buf_d[slot_idx] = nib;
            if (&seen_nx) begin
                // Completing edge: publish including the new nibble; the
                // buffer itself is kept, only the seen mask restarts.
                digits_d = buf_d;
                valid_d  = 1'b1;
                seen_d   = '0;
            end else begin
                seen_d = seen_nx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_q    <= SMP_IDLE;
            cnt_q    <= '0;
            buf_q    <= '0;
            seen_q   <= '0;
            digits_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            smp_q    <= smp_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
        end
    end

    assign digits = digits_q;
    assign valid  = valid_q;

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
`ifdef DISP_CAPTURE_ERR_EN
    logic err_q, err_d;
    logic multi_low;

    assign multi_low = (n_low > 3'd1);

    // A blank display (no anode low) is never an error.
    always_comb begin
        err_d = err_q;
        if (reach && (multi_low || (one_low && !dec_hit))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_disp_capture.sv
// tb_disp_capture: directed self-checking bench for disp_capture with
// STABLE=2. Each step drives one {an,seg} pattern for a number of clock
// edges, checks valid after every edge, then checks digits and err.
module tb_disp_capture;

    localparam int STABLE = 2;

`ifdef DISP_CAPTURE_ERR_EN
    localparam logic ERR_BUILD = 1'b1;
`else
    localparam logic ERR_BUILD = 1'b0;
`endif

    // Active-low gfedcba patterns, written out independently of the RTL.
    localparam logic [6:0] P0  = 7'b1000000;
    localparam logic [6:0] P1  = 7'b1111001;
    localparam logic [6:0] P2  = 7'b0100100;
    localparam logic [6:0] P3  = 7'b0110000;
    localparam logic [6:0] P4  = 7'b0011001;
    localparam logic [6:0] P5  = 7'b0010010;
    localparam logic [6:0] P6  = 7'b0000010;
    localparam logic [6:0] P7  = 7'b1111000;
    localparam logic [6:0] P8  = 7'b0000000;
    localparam logic [6:0] P9  = 7'b0010000;
    localparam logic [6:0] PA  = 7'b0001000;
    localparam logic [6:0] PB  = 7'b0000011;
    localparam logic [6:0] PC  = 7'b1000110;
    localparam logic [6:0] PD  = 7'b0100001;
    localparam logic [6:0] PE  = 7'b0000110;
    localparam logic [6:0] PF  = 7'b0001110;
    localparam logic [6:0] OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        valid;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    disp_capture #(.STABLE(STABLE)) dut (
        .clk    (clk),
        .reset  (reset),
        .an     (an),
        .seg    (seg),
        .digits (digits),
        .valid  (valid),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a pattern for n edges; valid must be high only after edge vedge
    // (0 = never). Afterwards digits and err are compared.
    task automatic step(input string tag, input logic [3:0] a, input logic [6:0] s,
                        input int n, input int vedge, input logic [15:0] dig_exp);
        an  = a;
        seg = s;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s valid@%0d", tag, k), {15'd0, valid}, {15'd0, (k == vedge)});
        end
        chk({tag, " digits"}, digits, dig_exp);
        chk({tag, " err"}, {15'd0, err}, {15'd0, err_exp});
        $display("step %-12s an=%b seg=%b n=%0d digits=%h valid_edge=%0d err=%b",
                 tag, a, s, n, digits, vedge, err);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " digits"}, digits, 16'h0000);
        chk({tag, " valid"}, {15'd0, valid}, 16'h0000);
        chk({tag, " err"}, {15'd0, err}, 16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        an    = 4'b1111;
        seg   = OFF;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        reset = 1'b0;

        // Partial frame (slots 0,1), then reset discards it.
        step("pre0", 4'b1110, P1, 3, 0, 16'h0000);
        step("pre1", 4'b1101, P2, 3, 0, 16'h0000);
        reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk);
        #1;
        chk_reset_outputs("midrst2");
        reset = 1'b0;

        // Slots 2,3 alone must not complete; then 0,1 finish the frame.
        step("post2", 4'b1011, P3, 3, 0, 16'h0000);
        step("post3", 4'b0111, P4, 3, 0, 16'h0000);
        step("post0", 4'b1110, P1, 3, 0, 16'h0000);
        step("post1", 4'b1101, P2, 3, 2, 16'h4321);

        // Basic frame 1,2,3,4 in order.
        step("f1_0", 4'b1110, P1, 3, 0, 16'h4321);
        step("f1_1", 4'b1101, P2, 3, 0, 16'h4321);
        step("f1_2", 4'b1011, P3, 3, 0, 16'h4321);
        step("f1_3", 4'b0111, P4, 3, 2, 16'h4321);

        // Slot 2 overwritten 5 -> A before slot 3.
        step("ow_0", 4'b1110, P8, 3, 0, 16'h4321);
        step("ow_1", 4'b1101, P0, 3, 0, 16'h4321);
        step("ow_2a", 4'b1011, P5, 3, 0, 16'h4321);
        step("ow_2b", 4'b1011, PA, 3, 0, 16'h4321);
        step("ow_3", 4'b0111, P3, 3, 2, 16'h3A08);

        // One-cycle glitches are ignored, including on the completing slot.
        step("gl_0", 4'b1110, P2, 3, 0, 16'h3A08);
        step("gl_g1", 4'b1101, P8, 1, 0, 16'h3A08);
        step("gl_1", 4'b1101, P1, 3, 0, 16'h3A08);
        step("gl_2", 4'b1011, P9, 3, 0, 16'h3A08);
        step("gl_g3", 4'b0111, P8, 1, 0, 16'h3A08);
        step("gl_3", 4'b0111, P7, 3, 2, 16'h7912);

        // Long hold gives one accept only.
        step("lh_0", 4'b1110, PB, 3, 0, 16'h7912);
        step("lh_1", 4'b1101, PC, 3, 0, 16'h7912);
        step("lh_2", 4'b1011, PD, 3, 0, 16'h7912);
        step("lh_3", 4'b0111, PE, 6, 2, 16'hEDCB);

        // Blank runs interleaved: no accept, no error.
        step("bl_0", 4'b1110, PF, 3, 0, 16'hEDCB);
        step("bl_b0", 4'b1111, OFF, 3, 0, 16'hEDCB);
        step("bl_1", 4'b1101, P6, 3, 0, 16'hEDCB);
        step("bl_b1", 4'b1111, P8, 2, 0, 16'hEDCB);
        step("bl_2", 4'b1011, P7, 3, 0, 16'hEDCB);
        step("bl_b2", 4'b1111, OFF, 3, 0, 16'hEDCB);
        step("bl_3", 4'b0111, P0, 3, 2, 16'h076F);

        // Error stimulus: two anodes low, then an unknown pattern.
        err_exp = ERR_BUILD;
        step("er_multi", 4'b1100, P1, 3, 0, 16'h076F);
        step("er_unk", 4'b1110, OFF, 3, 0, 16'h076F);
        step("er_1", 4'b1101, P1, 3, 0, 16'h076F);
        step("er_2", 4'b1011, P2, 3, 0, 16'h076F);
        step("er_3", 4'b0111, P3, 3, 2, 16'h3210);

        // Only reset clears err.
        reset = 1'b1;
        #1;
        err_exp = 1'b0;
        chk_reset_outputs("endrst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("fin_0", 4'b1110, P5, 3, 0, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
